// File: rtl/traffic_safety_monitor.sv
// Safety interlock between the junction light controller and the lamp drivers.
// Forwards lamp codes with one register of latency, or latches a fault and flashes all-red.
module traffic_safety_monitor #(
    parameter int MIN_YELLOW = 2,
    parameter int WATCHDOG   = 15,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [2:0]       M1_in,
    input  logic [2:0]       M2_in,
    input  logic [2:0]       MT_in,
    input  logic [2:0]       S_in,
    input  logic             clear,
    output logic [2:0]       M1,
    output logic [2:0]       M2,
    output logic [2:0]       MT,
    output logic [2:0]       S,
    output logic             fault,
    output logic [2:0]       fault_code
);

    localparam logic [2:0] RED  = 3'b100;
    localparam logic [2:0] YEL  = 3'b010;
    localparam logic [2:0] GRN  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;
    localparam logic [CNT_W-1:0] YMIN   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(WATCHDOG);

    logic [2:0]       cur [4];
    logic [2:0]       prev_code [4];
    logic [2:0]       lamp_p1 [4];
    logic [CNT_W-1:0] ycnt [4];
    logic [CNT_W-1:0] wdcnt;
    logic             phase;

    logic       bad_code, bad_step, short_y, any_change, all_red;
    logic       side_conflict, turn_conflict, clear_ok;
    logic [2:0] viol;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    function automatic logic legal_code(input logic [2:0] c);
        return (c == RED) || (c == YEL) || (c == GRN);
    endfunction

    function automatic logic legal_step(input logic [2:0] p, input logic [2:0] c);
        return (p == c) || (p == GRN && c == YEL) || (p == YEL && c == RED) || (p == RED && c == GRN);
    endfunction

    assign cur[0] = M1_in;
    assign cur[1] = M2_in;
    assign cur[2] = MT_in;
    assign cur[3] = S_in;

    assign side_conflict = (cur[3] != RED) && ((cur[0] != RED) || (cur[1] != RED) || (cur[2] != RED));
    assign turn_conflict = (cur[2] != RED) && (cur[1] != RED);

    always_comb begin
        bad_code   = 1'b0;
        bad_step   = 1'b0;
        short_y    = 1'b0;
        any_change = 1'b0;
        all_red    = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
            if (!legal_code(cur[ch])) bad_code = 1'b1;
            if (!legal_step(prev_code[ch], cur[ch])) bad_step = 1'b1;
            if (prev_code[ch] == YEL && cur[ch] == RED && ycnt[ch] < YMIN) short_y = 1'b1;
            if (cur[ch] != prev_code[ch]) any_change = 1'b1;
            if (cur[ch] != RED) all_red = 1'b0;
        end
        // Lowest cause code wins when several checks trip together
        viol = 3'd0;
        if (bad_code)             viol = 3'd1;
        else if (side_conflict)   viol = 3'd2;
        else if (turn_conflict)   viol = 3'd3;
        else if (bad_step)        viol = 3'd4;
        else if (short_y)         viol = 3'd5;
        else if (wdcnt == WD_LIM) viol = 3'd6;
    end

    assign clear_ok = fault && clear && all_red;

    // Output register stage: pass-through, fault entry, flashing, or clear
    always_ff @(posedge clk) begin
        if (reset || clear_ok) begin
            for (int ch = 0; ch < 4; ch++) begin
                lamp_p1[ch]   <= RED;
                prev_code[ch] <= RED;
                ycnt[ch]      <= '0;
            end
            wdcnt      <= '0;
            phase      <= 1'b0;
            fault      <= 1'b0;
            fault_code <= 3'd0;
        end else if (fault) begin
            if (tick) begin
                phase <= ~phase;
                for (int ch = 0; ch < 4; ch++) lamp_p1[ch] <= phase ? DARK : RED;
            end
        end else if (viol != 3'd0) begin
            fault      <= 1'b1;
            fault_code <= viol;
            phase      <= 1'b1;
            for (int ch = 0; ch < 4; ch++) lamp_p1[ch] <= RED;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                lamp_p1[ch]   <= cur[ch];
                prev_code[ch] <= cur[ch];
                if (prev_code[ch] == GRN && cur[ch] == YEL) ycnt[ch] <= '0;
                else if (tick && cur[ch] == YEL)          ycnt[ch] <= sat_inc(ycnt[ch]);
            end
            if (any_change) wdcnt <= '0;
            else if (tick)  wdcnt <= sat_inc(wdcnt);
        end
    end

    assign M1 = lamp_p1[0];
    assign M2 = lamp_p1[1];
    assign MT = lamp_p1[2];
    assign S  = lamp_p1[3];

endmodule
